// File: rtl/extref_pkg.sv
// Shared types and helpers for the multi-channel external reference clock monitor.
package extref_pkg;

  localparam int unsigned N_REF_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/extref_if.sv
// Refclk monitor bus: toggle inputs and force control in, qualification and selection out.
interface extref_if #(
  parameter int unsigned N_REF = 2,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned SEL_W = extref_pkg::sel_width(N_REF);

  logic [N_REF-1:0]       ref_tgl;
  logic                   force_sel_en;
  logic [SEL_W-1:0]       force_sel;
  logic [N_REF-1:0]       ref_ok;
  logic [N_REF*CNT_W-1:0] ref_meas;
  logic                   meas_valid;
  logic [SEL_W-1:0]       ref_sel;
  logic                   ref_sel_valid;
  logic                   serdes_rst;
  logic                   switch_pulse;

  modport master (
    output ref_tgl, force_sel_en, force_sel,
    input  ref_ok, ref_meas, meas_valid, ref_sel, ref_sel_valid, serdes_rst, switch_pulse
  );

  modport slave (
    input  ref_tgl, force_sel_en, force_sel,
    output ref_ok, ref_meas, meas_valid, ref_sel, ref_sel_valid, serdes_rst, switch_pulse
  );
endinterface

// File: rtl/extref_freq_chan.sv
// One refclk channel: toggle synchroniser, saturating edge counter, window latch and
// good-window streak qualification.
module extref_freq_chan
  import extref_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned EXP_CNT   = 1024,
  parameter int unsigned TOL       = 16,
  parameter int unsigned GOOD_WINS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgl,
  input  logic             win_wrap,
  output logic [CNT_W-1:0] meas,
  output logic             ok,
  output logic             ok_nxt_c
);
  localparam int unsigned STRK_W = $clog2(GOOD_WINS + 1);
  localparam int unsigned CMP_W  = CNT_W + 1;
  localparam logic [CMP_W-1:0] LO_LIM = (EXP_CNT > TOL) ? CMP_W'(EXP_CNT - TOL) : '0;
  localparam logic [CMP_W-1:0] HI_LIM = CMP_W'(EXP_CNT + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [STRK_W-1:0] STRK_FULL = STRK_W'(GOOD_WINS);

  logic [2:0]        sync;
  logic              edge_det;
  logic [CNT_W-1:0]  edge_cnt;
  logic [STRK_W-1:0] streak, streak_nxt;
  logic              good;

  // Flops 0/1 resynchronise; any change between flops 1 and 2 is one toggle edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], tgl};
  end

  assign edge_det = sync[2] ^ sync[1];

  // An edge seen in the wrap cycle opens the new window's count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  edge_cnt <= '0;
    else if (win_wrap)                        edge_cnt <= CNT_W'(edge_det);
    else if (edge_det && edge_cnt != CNT_MAX) edge_cnt <= edge_cnt + 1'b1;
  end

  assign good = ({1'b0, edge_cnt} >= LO_LIM) && ({1'b0, edge_cnt} <= HI_LIM);

  always_comb begin
    streak_nxt = streak;
    if (win_wrap) begin
      if (!good)                   streak_nxt = '0;
      else if (streak != STRK_FULL) streak_nxt = streak + 1'b1;
    end
  end

  assign ok_nxt_c = (streak_nxt == STRK_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
      ok     <= 1'b0;
      meas   <= '0;
    end else begin
      streak <= streak_nxt;
      ok     <= ok_nxt_c;
      if (win_wrap) meas <= edge_cnt;
    end
  end

endmodule

// File: rtl/extref_clk_monitor.sv
// Qualifies N_REF refclks by frequency, selects one and sequences the SERDES/PCS reset
// around every selection change.
module extref_clk_monitor
  import extref_pkg::*;
#(
  parameter int unsigned N_REF     = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned WIN_LEN   = 4096,
  parameter int unsigned EXP_CNT   = 1024,
  parameter int unsigned TOL       = 16,
  parameter int unsigned GOOD_WINS = 3,
  parameter int unsigned RST_HOLD  = 256,
  parameter int unsigned PREEMPT   = 0
) (
  input logic     clk,
  input logic     rst,
  extref_if.slave bus
);
  localparam int unsigned SEL_W  = sel_width(N_REF);
  localparam int unsigned WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

  logic [WIN_W-1:0]       win_cnt;
  logic                   win_wrap;
  logic [N_REF-1:0]       ok_q, ok_nxt;
  logic [N_REF*CNT_W-1:0] meas_q;
  logic                   meas_valid;
  state_e                 state, state_nxt;
  logic [SEL_W-1:0]       sel, sel_nxt, cand;
  logic                   cand_vld;
  logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
  logic                   serdes_rst, sel_valid, switch_pulse;

  assign win_wrap = (win_cnt == WIN_W'(WIN_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt    <= '0;
      meas_valid <= 1'b0;
    end else begin
      win_cnt    <= win_wrap ? '0 : win_cnt + 1'b1;
      meas_valid <= win_wrap;
    end
  end

  for (genvar i = 0; i < N_REF; i++) begin : g_chan
    extref_freq_chan #(
      .CNT_W    (CNT_W),
      .EXP_CNT  (EXP_CNT),
      .TOL      (TOL),
      .GOOD_WINS(GOOD_WINS)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tgl     (bus.ref_tgl[i]),
      .win_wrap(win_wrap),
      .meas    (meas_q[i*CNT_W +: CNT_W]),
      .ok      (ok_q[i]),
      .ok_nxt_c(ok_nxt[i])
    );
  end

  // Selection decisions look at the ok value being registered this edge, so a loss is
  // acted on in the same cycle ref_ok falls.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    if (bus.force_sel_en) begin
      if (32'(bus.force_sel) < N_REF) begin
        cand     = bus.force_sel;
        cand_vld = ok_nxt[bus.force_sel];
      end
    end else begin
      for (int i = int'(N_REF) - 1; i >= 0; i--) begin
        if (ok_nxt[i]) begin
          cand     = SEL_W'(i);
          cand_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    hold_nxt  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (cand_vld) begin
          state_nxt = RESET;
          sel_nxt   = cand;
          hold_nxt  = '0;
        end
      end
      RESET: begin
        if (!ok_nxt[sel])                            state_nxt = IDLE;
        else if (hold_cnt == HOLD_W'(RST_HOLD - 1)) state_nxt = RUN;
        else                                         hold_nxt  = hold_cnt + 1'b1;
      end
      RUN: begin
        if (!ok_nxt[sel]) begin
          state_nxt = IDLE;
        end else if (cand_vld && cand != sel && (PREEMPT != 0 || bus.force_sel_en)) begin
          state_nxt = RESET;
          sel_nxt   = cand;
          hold_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= '0;
      hold_cnt     <= '0;
      serdes_rst   <= 1'b1;
      sel_valid    <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      sel          <= sel_nxt;
      hold_cnt     <= hold_nxt;
      serdes_rst   <= (state_nxt != RUN);
      sel_valid    <= (state_nxt == RUN);
      switch_pulse <= (sel_nxt != sel);
    end
  end

  assign bus.ref_ok        = ok_q;
  assign bus.ref_meas      = meas_q;
  assign bus.meas_valid    = meas_valid;
  assign bus.ref_sel       = sel;
  assign bus.ref_sel_valid = sel_valid;
  assign bus.serdes_rst    = serdes_rst;
  assign bus.switch_pulse  = switch_pulse;

endmodule

// File: tb/tb_extref_clk_monitor.sv
// Randomised bench for extref_clk_monitor: two instances (no pre-emption / pre-emption)
// share stimulus and are compared every cycle against a window-level reference model.
module tb_extref_clk_monitor;
  localparam int N_REF     = 3;
  localparam int CNT_W     = 8;
  localparam int WIN_LEN   = 256;
  localparam int EXP_CNT   = 64;
  localparam int TOL       = 4;
  localparam int GOOD_WINS = 3;
  localparam int RST_HOLD  = 100;
  localparam int SEL_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_RESET = 1, M_RUN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  extref_if #(.N_REF(N_REF), .CNT_W(CNT_W)) bus0 ();
  extref_if #(.N_REF(N_REF), .CNT_W(CNT_W)) bus1 ();

  extref_clk_monitor #(
    .N_REF(N_REF), .CNT_W(CNT_W), .WIN_LEN(WIN_LEN), .EXP_CNT(EXP_CNT), .TOL(TOL),
    .GOOD_WINS(GOOD_WINS), .RST_HOLD(RST_HOLD), .PREEMPT(0)
  ) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  extref_clk_monitor #(
    .N_REF(N_REF), .CNT_W(CNT_W), .WIN_LEN(WIN_LEN), .EXP_CNT(EXP_CNT), .TOL(TOL),
    .GOOD_WINS(GOOD_WINS), .RST_HOLD(RST_HOLD), .PREEMPT(1)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [N_REF-1:0]       o_ok   [2];
  logic [N_REF*CNT_W-1:0] o_meas [2];
  logic [SEL_W-1:0]       o_sel  [2];
  logic [1:0]             o_mv, o_sv, o_srst, o_sw;

  assign o_ok[0] = bus0.ref_ok;     assign o_ok[1] = bus1.ref_ok;
  assign o_meas[0] = bus0.ref_meas; assign o_meas[1] = bus1.ref_meas;
  assign o_sel[0] = bus0.ref_sel;   assign o_sel[1] = bus1.ref_sel;
  assign o_mv   = {bus1.meas_valid,    bus0.meas_valid};
  assign o_sv   = {bus1.ref_sel_valid, bus0.ref_sel_valid};
  assign o_srst = {bus1.serdes_rst,    bus0.serdes_rst};
  assign o_sw   = {bus1.switch_pulse,  bus0.switch_pulse};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Stimulus state
  int               cyc;
  logic [N_REF-1:0] tgl;
  bit               fen;
  int               fsel;
  int               plan_n [N_REF];
  int               cur_n  [N_REF];
  int               st     [N_REF];

  // Reference model: edges binned by the window they land in, then per-window rules.
  int ecnt   [N_REF][4];
  int streak [N_REF];
  bit m_ok   [N_REF];
  int m_meas [N_REF];
  bit m_mv;
  int m_mode [2];
  int m_sel  [2];
  int m_hold [2];
  bit m_sw   [2];

  function automatic void model_reset();
    for (int c = 0; c < N_REF; c++) begin
      for (int k = 0; k < 4; k++) ecnt[c][k] = 0;
      streak[c] = 0; m_ok[c] = 0; m_meas[c] = 0;
    end
    m_mv = 0;
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = M_IDLE; m_sel[d] = 0; m_hold[d] = 0; m_sw[d] = 0;
    end
  endfunction

  function automatic int model_cand();
    if (fen) begin
      if (fsel < N_REF) begin
        if (m_ok[fsel]) return fsel;
      end
      return -1;
    end
    for (int i = 0; i < N_REF; i++) if (m_ok[i]) return i;
    return -1;
  endfunction

  function automatic void model_tick();
    int slot, c, prev;
    m_mv = 0;
    if (cyc % WIN_LEN == 0) begin
      slot = (cyc / WIN_LEN - 1) % 4;
      m_mv = 1;
      for (int ch = 0; ch < N_REF; ch++) begin
        m_meas[ch] = (ecnt[ch][slot] > CNT_MAX) ? CNT_MAX : ecnt[ch][slot];
        ecnt[ch][slot] = 0;
        if (m_meas[ch] >= EXP_CNT - TOL && m_meas[ch] <= EXP_CNT + TOL)
          streak[ch] = (streak[ch] < GOOD_WINS) ? streak[ch] + 1 : GOOD_WINS;
        else
          streak[ch] = 0;
        m_ok[ch] = (streak[ch] == GOOD_WINS);
      end
    end
    c = model_cand();
    for (int d = 0; d < 2; d++) begin
      prev = m_sel[d];
      case (m_mode[d])
        M_IDLE: if (c >= 0) begin
          m_mode[d] = M_RESET; m_sel[d] = c; m_hold[d] = RST_HOLD;
        end
        M_RESET: if (!m_ok[m_sel[d]]) m_mode[d] = M_IDLE;
                 else begin
                   m_hold[d]--;
                   if (m_hold[d] == 0) m_mode[d] = M_RUN;
                 end
        default: if (!m_ok[m_sel[d]]) m_mode[d] = M_IDLE;
                 else if (c >= 0 && c != m_sel[d] && (d == 1 || fen)) begin
                   m_mode[d] = M_RESET; m_sel[d] = c; m_hold[d] = RST_HOLD;
                 end
      endcase
      m_sw[d] = (m_sel[d] != prev);
    end
  endfunction

  task automatic drive_inputs();
    bus0.ref_tgl = tgl; bus0.force_sel_en = fen; bus0.force_sel = SEL_W'(fsel);
    bus1.ref_tgl = tgl; bus1.force_sel_en = fen; bus1.force_sel = SEL_W'(fsel);
  endtask

  // Codes: -1 toggle every cycle, -2 random good count, -3 random bad count.
  task automatic refresh_plan();
    for (int ch = 0; ch < N_REF; ch++) begin
      case (plan_n[ch])
        -2: cur_n[ch] = EXP_CNT - TOL + int'($urandom_range(0, 2 * TOL));
        -3: cur_n[ch] = ($urandom_range(0, 1) == 1) ? EXP_CNT + TOL + 1 + int'($urandom_range(0, 20))
                                                   : EXP_CNT - TOL - 1 - int'($urandom_range(0, 20));
        default: cur_n[ch] = plan_n[ch];
      endcase
      st[ch] = int'($urandom_range(0, 40));
    end
  endtask

  task automatic check_outputs();
    int okv;
    for (int d = 0; d < 2; d++) begin
      okv = 0;
      for (int ch = 0; ch < N_REF; ch++) if (m_ok[ch]) okv |= (1 << ch);
      check_val($sformatf("d%0d_ref_ok", d), longint'(o_ok[d]), longint'(okv));
      check_val($sformatf("d%0d_meas_valid", d), longint'(o_mv[d]), longint'(m_mv));
      check_val($sformatf("d%0d_serdes_rst", d), longint'(o_srst[d]), longint'(m_mode[d] != M_RUN));
      check_val($sformatf("d%0d_sel_valid", d), longint'(o_sv[d]), longint'(m_mode[d] == M_RUN));
      check_val($sformatf("d%0d_ref_sel", d), longint'(o_sel[d]), longint'(m_sel[d]));
      check_val($sformatf("d%0d_switch_pulse", d), longint'(o_sw[d]), longint'(m_sw[d]));
      if (m_mv)
        for (int ch = 0; ch < N_REF; ch++)
          check_val($sformatf("d%0d_meas%0d", d, ch),
                    longint'(o_meas[d][ch*CNT_W +: CNT_W]), longint'(m_meas[ch]));
    end
  endtask

  task automatic step();
    int o;
    bit t;
    @(posedge clk);
    cyc++;
    model_tick();
    #1;
    o = cyc % WIN_LEN;
    if (o == 0) refresh_plan();
    for (int ch = 0; ch < N_REF; ch++) begin
      t = (cur_n[ch] < 0) ||
          (o >= st[ch] && o < st[ch] + 2 * cur_n[ch] && ((o - st[ch]) % 2) == 0);
      if (t) begin
        tgl[ch] = ~tgl[ch];
        ecnt[ch][((cyc + 3) / WIN_LEN) % 4]++;
      end
    end
    drive_inputs();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_phase(input int nwin, input int n0, input int n1, input int n2,
                           input bit f_en, input int f_sel);
    plan_n[0] = n0; plan_n[1] = n1; plan_n[2] = n2;
    fen = f_en; fsel = f_sel;
    refresh_plan();
    drive_inputs();
    repeat (nwin * WIN_LEN) step();
  endtask

  task automatic do_reset(input int hold);
    #3 rst = 1'b1;
    tgl = '0;
    drive_inputs();
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("d%0d_rst_ref_ok", d), longint'(o_ok[d]), 0);
      check_val($sformatf("d%0d_rst_meas", d), longint'(o_meas[d]), 0);
      check_val($sformatf("d%0d_rst_meas_valid", d), longint'(o_mv[d]), 0);
      check_val($sformatf("d%0d_rst_ref_sel", d), longint'(o_sel[d]), 0);
      check_val($sformatf("d%0d_rst_sel_valid", d), longint'(o_sv[d]), 0);
      check_val($sformatf("d%0d_rst_serdes_rst", d), longint'(o_srst[d]), 1);
      check_val($sformatf("d%0d_rst_switch", d), longint'(o_sw[d]), 0);
    end
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  function automatic int pick_code();
    case ($urandom_range(0, 4))
      0: return 0;
      1: return -3;
      2: return EXP_CNT;
      default: return -2;
    endcase
  endfunction

  initial begin
    rst = 1'b1; tgl = '0; fen = 0; fsel = 0;
    for (int ch = 0; ch < N_REF; ch++) begin plan_n[ch] = 0; cur_n[ch] = 0; st[ch] = 0; end
    drive_inputs();
    model_reset();
    @(negedge clk);
    do_reset(4);

    run_phase(5, EXP_CNT, 0, 0, 0, 0);              // ch0 qualifies, reset hold, run
    run_phase(4, EXP_CNT, -2, 0, 0, 0);             // ch1 qualifies, ch0 keeps selection
    run_phase(2, 56, EXP_CNT, 0, 0, 0);             // ch0 slows: drop to IDLE, move to ch1
    run_phase(5, EXP_CNT, EXP_CNT, 0, 0, 0);        // ch0 back: only pre-empting instance moves
    run_phase(1, EXP_CNT - TOL, EXP_CNT, 0, 0, 0);  // tolerance boundaries
    run_phase(1, EXP_CNT + TOL, EXP_CNT, 0, 0, 0);
    run_phase(1, EXP_CNT - TOL - 1, EXP_CNT, 0, 0, 0);
    run_phase(1, EXP_CNT + TOL + 1, EXP_CNT, 0, 0, 0);
    run_phase(3, -1, EXP_CNT, 0, 0, 0);             // counter saturation
    run_phase(4, EXP_CNT, EXP_CNT, 0, 0, 0);
    run_phase(2, EXP_CNT, EXP_CNT, 0, 1, 1);        // forced switch to ch1
    run_phase(2, EXP_CNT, 0, 0, 1, 1);              // forced channel lost: stay IDLE
    run_phase(1, EXP_CNT, 0, 0, 1, 3);              // out-of-range force: no candidate
    run_phase(2, EXP_CNT, 0, 0, 0, 0);

    do_reset(3);
    run_phase(3, EXP_CNT, EXP_CNT, 0, 0, 0);
    repeat (30) step();                             // now mid RESET
    do_reset(5);
    run_phase(4, EXP_CNT, EXP_CNT, 0, 0, 0);

    for (int i = 0; i < 6; i++)
      run_phase(2, pick_code(), pick_code(), pick_code(),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
